// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
//
// Write bus between upstream time/alarm logic and the seven-segment scan
// driver. The master presents a new frame of digits, decimal points and
// blink flags. It asserts load for one cycle while ready is high. The slave
// (the scan driver) captures the data on that edge and drops ready until the
// data has been committed at the next frame boundary.
//
// Signals:
//   load           master -> slave  write strobe, honoured only while ready=1
//   ready          slave  -> master high when a new write can be accepted
//   digits_in[15:0] master -> slave four hex digits, digit p = [4p+3:4p]
//   dp_in[3:0]     master -> slave  decimal point per digit, 1 = lit
//   blink_mask_in  master -> slave  per-digit blink enable, 1 = blinks
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;
    logic        load;
    logic        ready;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask_in;

    modport master (
        output load,
        output digits_in,
        output dp_in,
        output blink_mask_in,
        input  ready
    );

    modport slave (
        input  load,
        input  digits_in,
        input  dp_in,
        input  blink_mask_in,
        output ready
    );
endinterface

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Four-digit, seven-segment scan driver. The 2-bit phase from the scan-clock
// divider selects the digit being shown. Every phase change turns all anodes
// off for BLANK_CYCLES+1 cycles, so the previous digit's segments do not ghost
// onto the next digit. After that interval the selected digit is driven and
// held until the next change.
//
// New content arrives through a ready/load handshake into a shadow copy. The
// shadow copy is promoted to the active copy only at a frame boundary, which
// is entry into phase 3. A whole scan frame therefore always shows one
// coherent set of digits.
//
// Parameters:
//   BLANK_CYCLES  anode-off cycles after each phase change (0..65535)
//   BLINK_FRAMES  scan frames per blink half-period (1..255)
//
// Ports:
//   clk_27Mhz     system clock
//   reset         synchronous, active-high reset
//   phase[1:0]    digit phase from the scan-clock divider
//   wr            write bus (slave side): load, ready, digits_in, dp_in,
//                 blink_mask_in
//   anode_n[3:0]  active-low digit enables, bit p = digit p
//   seg_n[6:0]    active-low segments {g,f,e,d,c,b,a}
//   dp_n          active-low decimal point
//
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN  When defined, digits 3..1 are blanked while
//                              they and every higher digit are zero. Digit 0
//                              is always shown.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_FRAMES = 68
) (
    input  logic             clk_27Mhz,
    input  logic             reset,
    input  logic [1:0]       phase,
    seg_scan_driver_if.slave wr,
    output logic [3:0]       anode_n,
    output logic [6:0]       seg_n,
    output logic             dp_n
);

    localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYCLES);
    localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

    // SCAN_BLANK: anodes off, counting down the anti-ghosting interval.
    // SCAN_HOLD:  the current digit has been driven (or nothing has been
    //             selected since reset); outputs hold until the next change.
    typedef enum logic {
        SCAN_HOLD,
        SCAN_BLANK
    } scan_state_t;

    typedef enum logic {
        BLINK_VISIBLE,
        BLINK_HIDDEN
    } blink_t;

    // Active copy (what is being scanned) and shadow copy (latest write).
    logic [15:0] act_digits;
    logic [3:0]  act_dp;
    logic [3:0]  act_mask;
    logic [15:0] sh_digits;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_mask;
    logic        pending;

    logic [1:0]  phase_q;
    logic [15:0] blank_cnt;
    logic [7:0]  frame_cnt;
    blink_t      blink_st;
    scan_state_t scan_st;

    logic        phase_change;
    logic        frame_boundary;
    logic [3:0]  cur_digit;
    logic [6:0]  seg_decoded;
    logic        lz_blank;
    logic        slot_blank;

    assign phase_change   = (phase != phase_q);
    assign frame_boundary = phase_change && (phase == 2'd3);
    assign cur_digit      = act_digits[{phase_q, 2'b00} +: 4];

    // Hex to active-low {g,f,e,d,c,b,a}.
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        seg_decoded = 7'h7F;
        case (cur_digit)
            4'h0: seg_decoded = 7'b1000000;
            4'h1: seg_decoded = 7'b1111001;
            4'h2: seg_decoded = 7'b0100100;
            4'h3: seg_decoded = 7'b0110000;
            4'h4: seg_decoded = 7'b0011001;
            4'h5: seg_decoded = 7'b0010010;
            4'h6: seg_decoded = 7'b0000010;
            4'h7: seg_decoded = 7'b1111000;
            4'h8: seg_decoded = 7'b0000000;
            4'h9: seg_decoded = 7'b0010000;
            4'hA: seg_decoded = 7'b0001000;
            4'hB: seg_decoded = 7'b0000011;
            4'hC: seg_decoded = 7'b1000110;
            4'hD: seg_decoded = 7'b0100001;
            4'hE: seg_decoded = 7'b0000110;
            4'hF: seg_decoded = 7'b0001110;
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        lz_blank = 1'b0;
        case (phase_q)
            2'd3:    lz_blank = (act_digits[15:12] == 4'h0);
            2'd2:    lz_blank = (act_digits[15:8]  == 8'h00);
            2'd1:    lz_blank = (act_digits[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign slot_blank = lz_blank ||
                        ((blink_st == BLINK_HIDDEN) && act_mask[phase_q]);

    // NOTE: all state in this block uses non-blocking assignments. Every
    // register then samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk_27Mhz) begin
        if (reset) begin
            act_digits <= '0;
            act_dp     <= '0;
            act_mask   <= '0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_mask    <= '0;
            pending    <= 1'b0;
            wr.ready   <= 1'b1;
            phase_q    <= 2'd0;
            blank_cnt  <= '0;
            frame_cnt  <= '0;
            blink_st   <= BLINK_VISIBLE;
            scan_st    <= SCAN_HOLD;
            anode_n    <= 4'hF;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
        end else begin
            // Handshake. ready mirrors ~pending, so a commit and an accepted
            // load can never fall on the same edge. A load accepted on a
            // boundary edge therefore waits for the following boundary.
            if (frame_boundary && pending) begin
                act_digits <= sh_digits;
                act_dp     <= sh_dp;
                act_mask   <= sh_mask;
                pending    <= 1'b0;
                wr.ready   <= 1'b1;
            end else if (wr.load && wr.ready) begin
                sh_digits  <= wr.digits_in;
                sh_dp      <= wr.dp_in;
                sh_mask    <= wr.blink_mask_in;
                pending    <= 1'b1;
                wr.ready   <= 1'b0;
            end

            // Blink timebase counts whole scan frames.
            if (frame_boundary) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    blink_st  <= (blink_st == BLINK_VISIBLE) ? BLINK_HIDDEN
                                                             : BLINK_VISIBLE;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end

            // Scan. A change always restarts the blank interval, even one
            // that is already running.
            if (phase_change) begin
                phase_q   <= phase;
                blank_cnt <= BLANK_LOAD;
                scan_st   <= SCAN_BLANK;
                anode_n   <= 4'hF;
                seg_n     <= 7'h7F;
                dp_n      <= 1'b1;
            end else begin
                case (scan_st)
                    SCAN_BLANK: begin
                        if (blank_cnt != 16'd0) begin
                            blank_cnt <= blank_cnt - 16'd1;
                        end else begin
                            scan_st <= SCAN_HOLD;
                            if (!slot_blank) begin
                                anode_n <= ~(4'b0001 << phase_q);
                                seg_n   <= seg_decoded;
                                dp_n    <= ~act_dp[phase_q];
                            end
                        end
                    end
                    default: ;  // SCAN_HOLD: outputs hold
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Randomised and directed stimulus for seg_scan_driver. On each cycle the
// stimulus side predicts, from a frame-level reference model, the outputs
// that follow the coming clock edge and pushes them into a queue. A separate
// monitor pops one entry per edge and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg_scan_driver;

    localparam int BLANK = 4;
    localparam int FRAMES = 2;

    typedef struct packed {
        logic [3:0] anode_n;
        logic [6:0] seg_n;
        logic       dp_n;
        logic       ready;
    } exp_t;

    logic       clk_27Mhz = 1'b0;
    logic       reset;
    logic [1:0] phase;
    logic [3:0] anode_n;
    logic [6:0] seg_n;
    logic       dp_n;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .BLANK_CYCLES(BLANK),
        .BLINK_FRAMES(FRAMES)
    ) dut (
        .clk_27Mhz (clk_27Mhz),
        .reset     (reset),
        .phase     (phase),
        .wr        (bus),
        .anode_n   (anode_n),
        .seg_n     (seg_n),
        .dp_n      (dp_n)
    );

    always #5 clk_27Mhz = ~clk_27Mhz;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F.
    logic [6:0] seg_lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model state: frame-level view of the display.
    logic [15:0] m_act_d, m_sh_d;
    logic [3:0]  m_act_dp, m_sh_dp, m_act_m, m_sh_m;
    bit          m_pending;
    logic [1:0]  m_phase;
    int          m_boundaries;
    int          m_edge;
    bit          m_changed;
    int          m_last_change;
    exp_t        m_disp;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // What slot p should show: the blink state follows from the number of
    // frame boundaries seen since reset.
    function automatic exp_t slot_view(input logic [1:0] p);
        exp_t e;
        bit   hidden;
        bit   blanked;
        hidden  = ((m_boundaries / FRAMES) % 2) == 1;
        blanked = hidden && m_act_m[p];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (p != 2'd0 && (m_act_d >> (4 * int'(p))) == 16'h0) blanked = 1'b1;
`endif
        e.ready = 1'b1;
        if (blanked) begin
            e.anode_n = 4'hF;
            e.seg_n   = 7'h7F;
            e.dp_n    = 1'b1;
        end else begin
            e.anode_n = ~(4'b0001 << p);
            e.seg_n   = seg_lut[m_act_d[4*p +: 4]];
            e.dp_n    = ~m_act_dp[p];
        end
        return e;
    endfunction

    // Drive one cycle's inputs and predict the outputs after the next edge.
    task automatic cycle(input bit rst, input logic [1:0] p, input bit ld,
                         input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] m);
        exp_t e;
        bit   chg;
        bit   bnd;
        @(negedge clk_27Mhz);
        reset             = rst;
        phase             = p;
        bus.load          = ld;
        bus.digits_in     = d;
        bus.dp_in         = dp;
        bus.blink_mask_in = m;
        if (rst) begin
            m_act_d = '0; m_act_dp = '0; m_act_m = '0;
            m_sh_d  = '0; m_sh_dp  = '0; m_sh_m  = '0;
            m_pending = 0; m_phase = 2'd0; m_boundaries = 0; m_changed = 0;
            e = '{anode_n: 4'hF, seg_n: 7'h7F, dp_n: 1'b1, ready: 1'b1};
        end else begin
            m_edge++;
            chg = (p != m_phase);
            bnd = chg && (p == 2'd3);
            if (bnd && m_pending) begin
                m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_act_m = m_sh_m;
                m_pending = 0;
            end else if (ld && !m_pending) begin
                m_sh_d = d; m_sh_dp = dp; m_sh_m = m;
                m_pending = 1;
            end
            if (bnd) m_boundaries++;
            if (chg) begin
                m_phase       = p;
                m_changed     = 1;
                m_last_change = m_edge;
                m_disp        = slot_view(p);
            end
            if (!m_changed || (m_edge - m_last_change) <= BLANK)
                e = '{anode_n: 4'hF, seg_n: 7'h7F, dp_n: 1'b1, ready: 1'b1};
            else
                e = m_disp;
            e.ready = !m_pending;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [1:0] p);
        cycle(0, p, 0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic load_word(input logic [1:0] p, input logic [15:0] d,
                             input logic [3:0] dp, input logic [3:0] m);
        cycle(0, p, 1, d, dp, m);
    endtask

    task automatic scan_frame(input int dwell);
        for (int p = 0; p < 4; p++)
            repeat (dwell) idle(2'(p));
    endtask

    // Monitor: one prediction per clock edge, sampled 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_27Mhz);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("anode_n", 16'(anode_n),  16'(e.anode_n));
                check("seg_n",   16'(seg_n),    16'(e.seg_n));
                check("dp_n",    16'(dp_n),     16'(e.dp_n));
                check("ready",   16'(bus.ready), 16'(e.ready));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] p;
        reset = 1'b1; phase = 2'd0; bus.load = 1'b0;
        bus.digits_in = '0; bus.dp_in = '0; bus.blink_mask_in = '0;
        m_edge = 0; m_last_change = 0;

        // Reset held, then released with phase held at 0: display stays dark.
        repeat (3) cycle(1, 2'd0, 0, 16'h0, 4'h0, 4'h0);
        repeat (6) idle(2'd0);

        // First write, committed at the first entry into phase 3.
        load_word(2'd0, 16'h12A8, 4'b0010, 4'b0000);
        repeat (2) idle(2'd0);
        repeat (3) scan_frame(7);

        // 2 -> 1 step, then a second change two cycles into the interval.
        repeat (8) idle(2'd2);
        repeat (2) idle(2'd1);
        repeat (8) idle(2'd0);
        repeat (8) idle(2'd1);

        // A second load while ready=0 is ignored.
        load_word(2'd1, 16'h3C4E, 4'b0001, 4'b0000);
        load_word(2'd1, 16'h9B7D, 4'b1000, 4'b1111);
        repeat (3) scan_frame(6);

        // Blink on digit 0.
        load_word(2'd0, 16'h4321, 4'b0000, 4'b0001);
        repeat (10) scan_frame(6);

        // Leading-zero values.
        load_word(2'd0, 16'h0005, 4'b1111, 4'b0000);
        repeat (2) scan_frame(6);
        load_word(2'd0, 16'h0000, 4'b0000, 4'b0000);
        repeat (2) scan_frame(6);
        load_word(2'd0, 16'h0070, 4'b0110, 4'b0000);
        repeat (2) scan_frame(6);

        // Reset in the middle of a handshake discards the shadow copy.
        load_word(2'd1, 16'hFEDC, 4'b1010, 4'b0000);
        idle(2'd2);
        cycle(1, 2'd2, 0, 16'h0, 4'h0, 4'h0);
        repeat (3) scan_frame(6);

        // Random phase jumps (including non-adjacent jumps and very short
        // dwells) and random writes.
        for (int i = 0; i < 1500; i++) begin
            p = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : m_phase;
            if ($urandom_range(0, 399) == 0)
                cycle(1, p, 0, 16'h0, 4'h0, 4'h0);
            else
                cycle(0, p, ($urandom_range(0, 7) == 0), 16'($urandom),
                      4'($urandom), 4'($urandom));
        end

        idle(m_phase);
        repeat (3) @(posedge clk_27Mhz);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
